// File: rtl/blake2_msg_sched_pkg.sv
// Shared definitions for the BLAKE2 message-word scheduler: index widths,
// the sigma permutation table, FSM state encoding and a rounds clamp helper.
package blake2_msg_sched_pkg;

  localparam int NUM_G      = 8;
  localparam int SIGMA_ROWS = 10;
  localparam int MSG_WORDS  = 16;

  localparam int IDX_W   = 4;
  localparam int ROW_W   = 4;
  localparam int STEP_W  = 3;
  localparam int ROUND_W = 4;

  localparam int ROUNDS_B2B = 12;
  localparam int ROUNDS_B2S = 10;

  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [ROW_W-1:0]  row_t;
  typedef logic [STEP_W-1:0] step_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // One row holds 16 four-bit word indices; entry j sits at nibble j, so the
  // hex literals read right-to-left in permutation order.
  typedef logic [MSG_WORDS-1:0][IDX_W-1:0] sigma_row_t;

  localparam sigma_row_t SIGMA [SIGMA_ROWS] = '{
    64'hFEDC_BA98_7654_3210,
    64'h357B_20C1_6DF9_84AE,
    64'h4917_63EA_DF25_0C8B,
    64'h8F04_A562_EBCD_1397,
    64'hD386_CB1E_FA42_7509,
    64'h91EF_57D4_38B0_A6C2,
    64'hB829_3670_A4DE_F15C,
    64'hA268_4F05_931C_E7BD,
    64'h5A41_7D2C_803B_9EF6,
    64'h0DC3_E9BF_5167_482A
  };

  // Limit a requested round count to what the round counter can hold.
  function automatic logic [ROUND_W-1:0] clamp_rounds(
    input logic [ROUND_W-1:0] req,
    input logic [ROUND_W-1:0] max_rounds
  );
    return (req > max_rounds) ? max_rounds : req;
  endfunction

endpackage

// File: rtl/blake2_msg_sched_lane.sv
// One G lane: looks up the (x, y) word indices for a sigma row and G step and
// selects the two message words from the latched block.
module blake2_sigma_lane
  import blake2_msg_sched_pkg::*;
#(
  parameter int W = 64
) (
  input  logic [MSG_WORDS*W-1:0] msg,
  input  row_t                   row,
  input  step_t                  step,
  output logic [W-1:0]           mx,
  output logic [W-1:0]           my
);

  idx_t         ix;
  idx_t         iy;
  logic [W-1:0] words [MSG_WORDS];

  // Unpack the flat block into words and pick the pair for this step.
  always_comb begin
    for (int i = 0; i < MSG_WORDS; i++) begin
      words[i] = msg[i*W +: W];
    end
    ix = SIGMA[row][{step, 1'b0}];
    iy = SIGMA[row][{step, 1'b1}];
    mx = words[ix];
    my = words[iy];
  end

endmodule

// File: rtl/blake2_msg_sched.sv
// BLAKE2 message-word scheduler: latches a 16-word block, then walks rounds
// and G steps, emitting G_LANES (mx, my) pairs per beat over valid/ready.
module blake2_msg_sched
  import blake2_msg_sched_pkg::*;
#(
  parameter int W          = 64,
  parameter int G_LANES    = 1,
  parameter int ROUNDS_MAX = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [MSG_WORDS*W-1:0] load_msg,
  input  logic [ROUND_W-1:0]     load_rounds,
  input  logic                   abort,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [G_LANES*W-1:0]   out_mx,
  output logic [G_LANES*W-1:0]   out_my,
  output logic [ROUND_W-1:0]     out_round,
  output logic [STEP_W-1:0]      out_step,
  output logic                   out_last,
  output logic                   busy
);

  localparam int          BPR       = NUM_G / G_LANES;
  localparam int          RCNT_W    = $clog2(ROUNDS_MAX + 1);
  localparam logic [2:0]  BEAT_LAST = 3'(BPR - 1);

  state_t                 state_q;
  logic [MSG_WORDS*W-1:0] msg_q;
  logic [RCNT_W-1:0]      round_q;
  logic [RCNT_W-1:0]      rounds_q;
  logic [2:0]             beat_q;

  logic [ROUND_W-1:0]     rounds_clamped;
  logic                   load_fire;
  logic                   beat_fire;
  logic                   beat_wrap;
  logic                   last_beat;
  row_t                   row;
  step_t                  lane_step [G_LANES];

  // Handshake qualifiers, row/step decode and status outputs from the registers.
  always_comb begin
    rounds_clamped = clamp_rounds(load_rounds, ROUND_W'(ROUNDS_MAX));
    load_ready     = (state_q == ST_IDLE) & ~abort;
    load_fire      = load_valid & load_ready;
    out_valid      = (state_q == ST_RUN);
    busy           = (state_q == ST_RUN);
    beat_wrap      = (beat_q == BEAT_LAST);
    last_beat      = out_valid & beat_wrap & (round_q == rounds_q - RCNT_W'(1));
    beat_fire      = out_valid & out_ready & ~abort;
    out_last       = last_beat;
    row            = ROW_W'(32'(round_q) % SIGMA_ROWS);
    out_round      = ROUND_W'(round_q);
    out_step       = STEP_W'(32'(beat_q) * G_LANES);
    for (int i = 0; i < G_LANES; i++) begin
      lane_step[i] = STEP_W'(32'(beat_q) * G_LANES + i);
    end
  end

  // Control FSM with round/beat counters; abort wins over load and advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      msg_q    <= '0;
      round_q  <= '0;
      beat_q   <= '0;
      rounds_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load_fire) begin
            msg_q    <= load_msg;
            rounds_q <= RCNT_W'(rounds_clamped);
            round_q  <= '0;
            beat_q   <= '0;
            state_q  <= (rounds_clamped != '0) ? ST_RUN : ST_IDLE;
          end
        end
        ST_RUN: begin
          if (abort) begin
            state_q <= ST_IDLE;
            round_q <= '0;
            beat_q  <= '0;
          end else if (beat_fire) begin
            if (last_beat) begin
              state_q <= ST_IDLE;
              round_q <= '0;
              beat_q  <= '0;
            end else if (beat_wrap) begin
              beat_q  <= '0;
              round_q <= round_q + RCNT_W'(1);
            end else begin
              beat_q  <= beat_q + 3'd1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < G_LANES; g++) begin : g_lane
    blake2_sigma_lane #(
      .W (W)
    ) u_lane (
      .msg  (msg_q),
      .row  (row),
      .step (lane_step[g]),
      .mx   (out_mx[g*W +: W]),
      .my   (out_my[g*W +: W])
    );
  end

endmodule

// File: tb/tb_blake2_msg_sched.sv
// Bench for blake2_msg_sched: two instances (W=64/1 lane and W=32/4 lanes)
// driven through a shared stimulus path and compared against a beat-level model.
module tb_blake2_msg_sched;

  localparam int SIG [10][16] = '{
    '{ 0,  1,  2,  3,  4,  5,  6,  7,  8,  9, 10, 11, 12, 13, 14, 15},
    '{14, 10,  4,  8,  9, 15, 13,  6,  1, 12,  0,  2, 11,  7,  5,  3},
    '{11,  8, 12,  0,  5,  2, 15, 13, 10, 14,  3,  6,  7,  1,  9,  4},
    '{ 7,  9,  3,  1, 13, 12, 11, 14,  2,  6,  5, 10,  4,  0, 15,  8},
    '{ 9,  0,  5,  7,  2,  4, 10, 15, 14,  1, 11, 12,  6,  8,  3, 13},
    '{ 2, 12,  6, 10,  0, 11,  8,  3,  4, 13,  7,  5, 15, 14,  1,  9},
    '{12,  5,  1, 15, 14, 13,  4, 10,  0,  7,  6,  3,  9,  2,  8, 11},
    '{13, 11,  7, 14, 12,  1,  3,  9,  5,  0, 15,  4,  8,  6,  2, 10},
    '{ 6, 15, 14,  9, 11,  3,  0,  8, 12,  2, 13,  7,  1,  4, 10,  5},
    '{10,  2,  8,  4,  7,  6,  1,  5, 15, 11,  9, 14,  3, 12, 13,  0}
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        load_valid = 1'b0;
  logic        abort = 1'b0;
  logic        out_ready = 1'b0;
  logic [3:0]  load_rounds = 4'd0;
  logic [63:0] m [16];

  always #5 clk = ~clk;

  logic [16*64-1:0] a_msg;
  logic [16*32-1:0] b_msg;
  logic a_lv, a_ab, a_or, b_lv, b_ab, b_or;
  logic a_load_ready, a_out_valid, a_out_last, a_busy;
  logic b_load_ready, b_out_valid, b_out_last, b_busy;
  logic [63:0]  a_mx, a_my;
  logic [127:0] b_mx, b_my;
  logic [3:0]   a_round, b_round;
  logic [2:0]   a_step, b_step;

  assign a_lv = load_valid & ~sel;
  assign a_ab = abort & ~sel;
  assign a_or = out_ready & ~sel;
  assign b_lv = load_valid & sel;
  assign b_ab = abort & sel;
  assign b_or = out_ready & sel;

  // Flatten the message array for both widths.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      a_msg[i*64 +: 64] = m[i];
      b_msg[i*32 +: 32] = m[i][31:0];
    end
  end

  blake2_msg_sched #(.W(64), .G_LANES(1), .ROUNDS_MAX(12)) u_dut_a (
    .clk (clk), .rst_n (rst_n),
    .load_valid (a_lv), .load_ready (a_load_ready), .load_msg (a_msg),
    .load_rounds (load_rounds), .abort (a_ab),
    .out_valid (a_out_valid), .out_ready (a_or),
    .out_mx (a_mx), .out_my (a_my), .out_round (a_round), .out_step (a_step),
    .out_last (a_out_last), .busy (a_busy)
  );

  blake2_msg_sched #(.W(32), .G_LANES(4), .ROUNDS_MAX(12)) u_dut_b (
    .clk (clk), .rst_n (rst_n),
    .load_valid (b_lv), .load_ready (b_load_ready), .load_msg (b_msg),
    .load_rounds (load_rounds), .abort (b_ab),
    .out_valid (b_out_valid), .out_ready (b_or),
    .out_mx (b_mx), .out_my (b_my), .out_round (b_round), .out_step (b_step),
    .out_last (b_out_last), .busy (b_busy)
  );

  logic        obs_valid, obs_load_ready, obs_last, obs_busy;
  logic [3:0]  obs_round;
  logic [2:0]  obs_step;
  logic [63:0] obs_mx [4];
  logic [63:0] obs_my [4];

  // Present the selected instance's outputs in a common shape.
  always_comb begin
    for (int l = 0; l < 4; l++) begin
      obs_mx[l] = 64'd0;
      obs_my[l] = 64'd0;
    end
    if (sel) begin
      obs_valid = b_out_valid; obs_load_ready = b_load_ready;
      obs_last = b_out_last; obs_busy = b_busy;
      obs_round = b_round; obs_step = b_step;
      for (int l = 0; l < 4; l++) begin
        obs_mx[l] = {32'd0, b_mx[l*32 +: 32]};
        obs_my[l] = {32'd0, b_my[l*32 +: 32]};
      end
    end else begin
      obs_valid = a_out_valid; obs_load_ready = a_load_ready;
      obs_last = a_out_last; obs_busy = a_busy;
      obs_round = a_round; obs_step = a_step;
      obs_mx[0] = a_mx;
      obs_my[0] = a_my;
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected word for round r, G step s, y=0 for x word and 1 for y word.
  function automatic logic [63:0] exp_word(input int r, input int s, input int y);
    logic [63:0] v;
    v = m[SIG[r % 10][2*s + y]];
    if (sel) v = {32'd0, v[31:0]};
    return v;
  endfunction

  task automatic set_msg(input int mode);
    for (int i = 0; i < 16; i++) begin
      case (mode)
        0:       m[i] = 64'(i);
        1:       m[i] = 64'(15 - i);
        default: m[i] = {$urandom, $urandom};
      endcase
    end
  endtask

  // Load one block and follow it beat by beat; optional abort or reset at beat k.
  task automatic run_block(input int req, input int stall_pct, input int abort_at, input int rst_at);
    int g, bpr, eff, total, k, cyc, r, s;
    g = sel ? 4 : 1;
    bpr = 8 / g;
    eff = (req > 12) ? 12 : req;
    total = eff * bpr;
    @(negedge clk);
    chk("load_ready idle", 64'(obs_load_ready), 64'd1);
    load_valid = 1'b1;
    load_rounds = 4'(req);
    @(negedge clk);
    load_valid = 1'b0;
    if (total == 0) begin
      chk("zero rounds busy", 64'(obs_busy), 64'd0);
      chk("zero rounds valid", 64'(obs_valid), 64'd0);
      return;
    end
    k = 0;
    cyc = 0;
    while (k < total) begin
      if (cyc > 4000) begin
        chk("beat budget", 64'(k), 64'(total));
        return;
      end
      r = k / bpr;
      chk($sformatf("valid k=%0d", k), 64'(obs_valid), 64'd1);
      chk($sformatf("busy k=%0d", k), 64'(obs_busy), 64'd1);
      chk($sformatf("load_ready run k=%0d", k), 64'(obs_load_ready), 64'd0);
      chk($sformatf("round k=%0d", k), 64'(obs_round), 64'(r));
      chk($sformatf("step k=%0d", k), 64'(obs_step), 64'((k % bpr) * g));
      chk($sformatf("last k=%0d", k), 64'(obs_last), 64'(k == total - 1));
      for (int l = 0; l < g; l++) begin
        s = (k % bpr) * g + l;
        chk($sformatf("mx k=%0d l=%0d", k, l), obs_mx[l], exp_word(r, s, 0));
        chk($sformatf("my k=%0d l=%0d", k, l), obs_my[l], exp_word(r, s, 1));
      end
      if (k == abort_at) begin
        abort = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("abort valid", 64'(obs_valid), 64'd0);
        chk("abort load_ready", 64'(obs_load_ready), 64'd1);
        chk("abort busy", 64'(obs_busy), 64'd0);
        return;
      end
      if (k == rst_at) begin
        out_ready = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("reset valid", 64'(obs_valid), 64'd0);
        chk("reset load_ready", 64'(obs_load_ready), 64'd1);
        chk("reset busy", 64'(obs_busy), 64'd0);
        chk("reset last", 64'(obs_last), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b0;
        return;
      end
      out_ready = ($urandom_range(99) >= stall_pct);
      if (out_ready) k++;
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    chk("end busy", 64'(obs_busy), 64'd0);
    chk("end valid", 64'(obs_valid), 64'd0);
    chk("end last", 64'(obs_last), 64'd0);
    chk("end load_ready", 64'(obs_load_ready), 64'd1);
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    set_msg(0);
    #1;
    chk("rst a valid", 64'(a_out_valid), 64'd0);
    chk("rst a busy", 64'(a_busy), 64'd0);
    chk("rst a last", 64'(a_out_last), 64'd0);
    chk("rst a load_ready", 64'(a_load_ready), 64'd1);
    chk("rst b valid", 64'(b_out_valid), 64'd0);
    chk("rst b load_ready", 64'(b_load_ready), 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single lane, W=64, m[i]=i, 12 rounds, no backpressure.
    sel = 1'b0; set_msg(0); run_block(12, 0, -1, -1);
    // Four lanes, W=32, same message.
    sel = 1'b1; set_msg(0); run_block(12, 0, -1, -1);
    // BLAKE2s round count with random words.
    set_msg(2); run_block(10, 0, -1, -1);
    // Over-range round request clamps to 12, under backpressure.
    sel = 1'b0; set_msg(2); run_block(15, 40, -1, -1);
    // Zero rounds: block accepted and dropped.
    run_block(0, 0, -1, -1);
    // Random blocks with heavy backpressure on the wide instance.
    sel = 1'b1;
    for (int t = 0; t < 4; t++) begin
      set_msg(2);
      run_block(int'($urandom_range(1, 15)), 50, -1, -1);
    end
    // Abort while idle blocks the load.
    sel = 1'b0;
    @(negedge clk);
    abort = 1'b1; load_valid = 1'b1; load_rounds = 4'd12;
    #1;
    chk("idle abort load_ready", 64'(obs_load_ready), 64'd0);
    @(negedge clk);
    abort = 1'b0; load_valid = 1'b0;
    #1;
    chk("idle abort busy", 64'(obs_busy), 64'd0);
    chk("idle abort valid", 64'(obs_valid), 64'd0);
    // Abort at round 3 beat 2, then reload reversed message from beat 0.
    set_msg(0); run_block(12, 0, 26, -1);
    set_msg(1); run_block(12, 0, -1, -1);
    // Asynchronous reset mid-run, then a fresh full block.
    sel = 1'b1;
    set_msg(2); run_block(12, 20, -1, 5);
    set_msg(2); run_block(12, 30, -1, -1);
    sel = 1'b0;
    set_msg(2); run_block(12, 0, -1, 40);
    set_msg(2); run_block(3, 25, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
